// File: rtl/legup_pkg.sv
// legup_pkg: shared FSM state type and widths for the legup register blocks.
package legup_pkg;
    typedef enum logic [1:0] {RR_EMPTY, RR_ONE, RR_TWO} rr_state_t;
    localparam int RR_STALL_CNT_W = 32;
endpackage

// File: rtl/legup_register.sv
// legup_register: single loadable word with synchronous active-low reset to init_value.
module legup_register #(
    parameter int width = 32,
    parameter logic [width-1:0] init_value = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    always_ff @(posedge clk)
        if (!reset) q <= init_value;
        else if (load) q <= d;
endmodule

// File: rtl/legup_register_reader.sv
// legup_register_reader: 2-entry skid-buffered valid/ready pipeline register.
// Optional LEGUP_REG_READER_STALL_CNT_EN adds a saturating stall_count output.
module legup_register_reader
    import legup_pkg::*;
#(
    parameter int width = 32,
    parameter logic [width-1:0] init_value = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data
`ifdef LEGUP_REG_READER_STALL_CNT_EN
    ,
    output logic [RR_STALL_CNT_W-1:0] stall_count
`endif
);
    rr_state_t state, state_nxt;
    logic accept, consume, main_load, skid_load;
    logic [width-1:0] skid_q, main_d;
    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;
    // Main refills from the skid word when draining TWO, otherwise straight from the input.
    assign main_d    = state == RR_TWO ? skid_q : in_data;
    assign main_load = state == RR_TWO ? consume : accept & (state == RR_EMPTY | consume);
    assign skid_load = state == RR_ONE & accept & ~consume;
    always_comb
        state_nxt = state == RR_EMPTY ? (accept ? RR_ONE : RR_EMPTY) :
                    state == RR_ONE   ? (skid_load ? RR_TWO : (consume & ~accept) ? RR_EMPTY : RR_ONE) :
                    state == RR_TWO   ? (consume ? RR_ONE : RR_TWO) : RR_EMPTY;
    always_ff @(posedge clk)
        if (!reset) begin
            state     <= RR_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= state_nxt != RR_EMPTY;
            in_ready  <= state_nxt != RR_TWO;
        end
    legup_register #(.width(width), .init_value(init_value)) u_main (
        .clk(clk), .reset(reset), .load(main_load), .d(main_d), .q(out_data)
    );
    legup_register #(.width(width), .init_value(init_value)) u_skid (
        .clk(clk), .reset(reset), .load(skid_load), .d(in_data), .q(skid_q)
    );
`ifdef LEGUP_REG_READER_STALL_CNT_EN
    always_ff @(posedge clk)
        if (!reset) stall_count <= '0;
        else if (out_valid & ~out_ready & ~&stall_count) stall_count <= stall_count + 1'b1;
`endif
endmodule

// File: tb/tb_legup_register_reader.sv
// tb_legup_register_reader: queue-model scoreboard with directed phases and random traffic.
module tb_legup_register_reader;
    localparam int W = 32;
    localparam logic [W-1:0] INIT = 32'hA5A5_0F0F;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    int total = 0;
    int bad = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] last;
    logic exp_rdy;
`ifdef LEGUP_REG_READER_STALL_CNT_EN
    logic [31:0] stall_count, exp_stall;
`endif
    always #5 clk = ~clk;
    legup_register_reader #(.width(W), .init_value(INIT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef LEGUP_REG_READER_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );
    // Reference: the block is a 2-deep FIFO; in_ready is "fewer than 2 held" as of the last edge.
    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            last = INIT;
            exp_rdy = 1'b0;
`ifdef LEGUP_REG_READER_STALL_CNT_EN
            exp_stall = 0;
`endif
        end else begin
            logic acc, con;
            acc = in_valid && exp_rdy;
            con = out_ready && q.size() > 0;
`ifdef LEGUP_REG_READER_STALL_CNT_EN
            if (q.size() > 0 && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
            if (con) last = q.pop_front();
            if (acc) q.push_back(in_data);
            exp_rdy = q.size() < 2;
        end
    end
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask
    always @(negedge clk) begin
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        check("out_data", out_data, q.size() > 0 ? q[0] : last);
`ifdef LEGUP_REG_READER_STALL_CNT_EN
        check("stall_count", stall_count, exp_stall);
`endif
    end
    task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy, input logic rst);
        in_valid = iv;
        in_data = d;
        out_ready = ordy;
        reset = rst;
        @(posedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= 100; i++) cyc(1'b1, i, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, 32'hAAAA_0001, 1'b0, 1'b1);
        cyc(1'b1, 32'hBBBB_0002, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'hFFFF_0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, 32'hC0C0_0000, 1'b0, 1'b1);
        cyc(1'b1, 32'hC0C0_0001, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, 32'h1111_1111, 1'b0, 1'b1);
        cyc(1'b1, 32'h2222_2222, 1'b0, 1'b1);
        cyc(1'b1, 32'h3333_3333, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 10000; i++)
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 999) != 0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
